// File: rtl/sr_latch_ctrl.sv
// Pulse sequencer for an external SR latch: round-robin arbitration of set/clear
// requests, fixed-width drive pulses, recovery gaps and feedback checking.
module sr_latch_ctrl #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic latch_set,
    output logic latch_reset,
    output logic set_ack,
    output logic clr_ack,
    output logic busy,
    output logic q_shadow,
    output logic q_valid,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE,
        SET_PULSE,
        RST_PULSE,
        GAP
    } state_t;

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       rr_favor_set;
    logic       any_req;
    logic       grant_set;
    logic       redundant;
    logic       pulse_is_set;

    // When both requests are pending the kind not granted last time wins.
    assign any_req      = set_req | clr_req;
    assign grant_set    = set_req & (~clr_req | rr_favor_set);
    assign redundant    = q_valid & (q_shadow == grant_set);
    assign pulse_is_set = (state == SET_PULSE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            latch_set    <= 1'b0;
            latch_reset  <= 1'b0;
            set_ack      <= 1'b0;
            clr_ack      <= 1'b0;
            busy         <= 1'b0;
            q_shadow     <= 1'b0;
            q_valid      <= 1'b0;
            err          <= 1'b0;
            rr_favor_set <= 1'b1;
        end else begin
            set_ack <= 1'b0;
            clr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        rr_favor_set <= ~grant_set;
                        if (redundant) begin
                            set_ack <= grant_set;
                            clr_ack <= ~grant_set;
                        end else if (grant_set) begin
                            state     <= SET_PULSE;
                            cnt       <= PULSE_LOAD;
                            latch_set <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state       <= RST_PULSE;
                            cnt         <= PULSE_LOAD;
                            latch_reset <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end
                end
                SET_PULSE, RST_PULSE: begin
                    if (cnt == 4'd0) begin
                        // Pulse done: the latch should now hold the driven value.
                        state       <= GAP;
                        cnt         <= GAP_LOAD;
                        latch_set   <= 1'b0;
                        latch_reset <= 1'b0;
                        set_ack     <= pulse_is_set;
                        clr_ack     <= ~pulse_is_set;
                        q_shadow    <= pulse_is_set;
                        q_valid     <= 1'b1;
                        if (q_fb != pulse_is_set) begin
                            err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                GAP: begin
                    if (cnt == 4'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Randomized self-checking bench for sr_latch_ctrl: two instances (default and 5/3 timing)
// against a timeline-based reference model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_sr_latch_ctrl;
    localparam int NDUT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NDUT-1:0] set_req = '0;
    logic [NDUT-1:0] clr_req = '0;
    logic [NDUT-1:0] stuck_low = '0;
    logic [NDUT-1:0] lq = '0;
    logic [NDUT-1:0] q_fb;
    logic [NDUT-1:0] latch_set, latch_reset, set_ack, clr_ack, busy, q_shadow, q_valid, err;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    sr_latch_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .set_req(set_req[0]), .clr_req(clr_req[0]), .q_fb(q_fb[0]),
        .latch_set(latch_set[0]), .latch_reset(latch_reset[0]), .set_ack(set_ack[0]),
        .clr_ack(clr_ack[0]), .busy(busy[0]), .q_shadow(q_shadow[0]), .q_valid(q_valid[0]),
        .err(err[0])
    );

    sr_latch_ctrl #(.PULSE_CYCLES(5), .GAP_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .set_req(set_req[1]), .clr_req(clr_req[1]), .q_fb(q_fb[1]),
        .latch_set(latch_set[1]), .latch_reset(latch_reset[1]), .set_ack(set_ack[1]),
        .clr_ack(clr_ack[1]), .busy(busy[1]), .q_shadow(q_shadow[1]), .q_valid(q_valid[1]),
        .err(err[1])
    );

    function automatic int pw(input int i);
        return (i == 0) ? 2 : 5;
    endfunction

    function automatic int gw(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Behavioural SR latch; stuck_low models a broken feedback path.
    assign q_fb = lq & ~stuck_low;
    always @(latch_set or latch_reset) begin
        for (int i = 0; i < NDUT; i++) begin
            if (latch_set[i]) lq[i] = 1'b1;
            else if (latch_reset[i]) lq[i] = 1'b0;
        end
    end

    // Reference model: each grant is a transaction with a start cycle; outputs follow from
    // the cycle offset into that transaction.
    bit       m_active [NDUT];
    bit       m_kind [NDUT];
    int       m_start [NDUT];
    int       m_free [NDUT];
    bit       m_last_set [NDUT];
    bit       m_qsh [NDUT];
    bit       m_qv [NDUT];
    bit       m_err [NDUT];
    int       m_red_at [NDUT];
    bit       m_red_kind [NDUT];
    bit [7:0] exp_out [NDUT];
    int       ncyc = 0;

    task automatic modelReset();
        for (int i = 0; i < NDUT; i++) begin
            m_active[i] = 1'b0;
            m_last_set[i] = 1'b0;
            m_qsh[i] = 1'b0;
            m_qv[i] = 1'b0;
            m_err[i] = 1'b0;
            m_free[i] = 0;
            m_red_at[i] = -1;
            exp_out[i] = '0;
        end
    endtask

    task automatic modelStep(input int i);
        bit kind;
        int d;
        bit s_o, r_o, sa, ca, b;
        if (!m_active[i] && ncyc >= m_free[i] && (set_req[i] || clr_req[i])) begin
            kind = (set_req[i] && clr_req[i]) ? !m_last_set[i] : set_req[i];
            m_last_set[i] = kind;
            if (m_qv[i] && m_qsh[i] == kind) begin
                m_red_at[i] = ncyc;
                m_red_kind[i] = kind;
                m_free[i] = ncyc + 1;
            end else begin
                m_active[i] = 1'b1;
                m_kind[i] = kind;
                m_start[i] = ncyc;
            end
        end
        d = ncyc - m_start[i];
        s_o = m_active[i] && m_kind[i] && d < pw(i);
        r_o = m_active[i] && !m_kind[i] && d < pw(i);
        sa = (m_active[i] && m_kind[i] && d == pw(i)) || (m_red_at[i] == ncyc && m_red_kind[i]);
        ca = (m_active[i] && !m_kind[i] && d == pw(i)) || (m_red_at[i] == ncyc && !m_red_kind[i]);
        b = m_active[i] && d < pw(i) + gw(i);
        if (m_active[i] && d == pw(i)) begin
            m_qsh[i] = m_kind[i];
            m_qv[i] = 1'b1;
            if (q_fb[i] != m_kind[i]) m_err[i] = 1'b1;
        end
        if (m_active[i] && d == pw(i) + gw(i) - 1) begin
            m_active[i] = 1'b0;
            m_free[i] = ncyc + 2;
        end
        exp_out[i] = {s_o, r_o, sa, ca, b, m_qsh[i], m_qv[i], m_err[i]};
    endtask

    task automatic modelTick();
        ncyc++;
        for (int i = 0; i < NDUT; i++) modelStep(i);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) modelReset();
        else modelTick();
    end

    function automatic string outName(input int b);
        case (b)
            7: return "latch_set";
            6: return "latch_reset";
            5: return "set_ack";
            4: return "clr_ack";
            3: return "busy";
            2: return "q_shadow";
            1: return "q_valid";
            default: return "err";
        endcase
    endfunction

    task automatic checkOutput(input int i);
        logic [7:0] act;
        act = {latch_set[i], latch_reset[i], set_ack[i], clr_ack[i], busy[i], q_shadow[i], q_valid[i], err[i]};
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (act[b] !== exp_out[i][b]) begin
                errors++;
                $display("[TB] FAIL dut%0d %s got %b want %b at %0t", i, outName(b), act[b], exp_out[i][b], $time);
            end
        end
        checks++;
        if (latch_set[i] === 1'b1 && latch_reset[i] === 1'b1) begin
            errors++;
            $display("[TB] FAIL dut%0d drive_overlap got set=1 reset=1 want not both at %0t", i, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < NDUT; i++) checkOutput(i);
        end
    end

    task automatic checkLit(input string name, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s got %b want %b at %0t", name, act, want, $time);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("[TB] FAIL %s got %0d want %0d at %0t", name, act, want, $time);
        end
    endtask

    // Raise one request, hold it until acknowledged (bounded), then drop it.
    task automatic runReq(input int i, input bit want_set, input string name);
        bit seen;
        seen = 1'b0;
        if (want_set) set_req[i] = 1'b1;
        else clr_req[i] = 1'b1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = want_set ? set_ack[i] : clr_ack[i];
            #1;
        end
        if (want_set) set_req[i] = 1'b0;
        else clr_req[i] = 1'b0;
        checkLit(name, seen, 1'b1);
    endtask

    task automatic applyStimulus();
        if (!rst_n) rst_n = 1'b1;
        else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            if ($urandom_range(0, 63) == 0) stuck_low[i] = ~stuck_low[i];
            if (set_req[i] && set_ack[i]) set_req[i] = 1'b0;
            else if (!set_req[i] && $urandom_range(0, 3) == 0) set_req[i] = 1'b1;
            else if (set_req[i] && $urandom_range(0, 31) == 0) set_req[i] = 1'b0;
            if (clr_req[i] && clr_ack[i]) clr_req[i] = 1'b0;
            else if (!clr_req[i] && $urandom_range(0, 3) == 0) clr_req[i] = 1'b1;
            else if (clr_req[i] && $urandom_range(0, 31) == 0) clr_req[i] = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int sack_cyc, cack_cyc, overlap, rs_w, ls_w, last_rs, first_ls, first_rs;
        bit seen;

        repeat (2) @(negedge clk);
        check_en = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            checkLit($sformatf("rst_latch_set%0d", i), latch_set[i], 1'b0);
            checkLit($sformatf("rst_busy%0d", i), busy[i], 1'b0);
            checkLit($sformatf("rst_q_valid%0d", i), q_valid[i], 1'b0);
            checkLit($sformatf("rst_err%0d", i), err[i], 1'b0);
        end

        // Single set request with default timing.
        #1 rst_n = 1'b1;
        set_req[0] = 1'b1;
        @(negedge clk);
        checkLit("set_c1_latch_set", latch_set[0], 1'b1);
        checkLit("set_c1_busy", busy[0], 1'b1);
        @(negedge clk);
        checkLit("set_c2_latch_set", latch_set[0], 1'b1);
        checkLit("set_c2_set_ack", set_ack[0], 1'b0);
        @(negedge clk);
        checkLit("set_c3_latch_set", latch_set[0], 1'b0);
        checkLit("set_c3_set_ack", set_ack[0], 1'b1);
        checkLit("set_c3_q_shadow", q_shadow[0], 1'b1);
        checkLit("set_c3_q_valid", q_valid[0], 1'b1);
        checkLit("set_c3_err", err[0], 1'b0);
        checkLit("set_c3_busy", busy[0], 1'b1);
        #1 set_req[0] = 1'b0;
        @(negedge clk);
        checkLit("set_c4_busy", busy[0], 1'b0);
        checkLit("set_c4_set_ack", set_ack[0], 1'b0);

        // Redundant set: ack next cycle, no pulse.
        #1 set_req[0] = 1'b1;
        @(negedge clk);
        checkLit("redundant_set_ack", set_ack[0], 1'b1);
        checkLit("redundant_latch_set", latch_set[0], 1'b0);
        checkLit("redundant_busy", busy[0], 1'b0);
        #1 set_req[0] = 1'b0;
        @(negedge clk);
        checkLit("redundant_ack_once", set_ack[0], 1'b0);

        // Both requests together after reset: set first, then clear.
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        set_req[0] = 1'b1;
        clr_req[0] = 1'b1;
        sack_cyc = 0;
        cack_cyc = 0;
        overlap = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (set_ack[0] && sack_cyc == 0) sack_cyc = k;
            if (clr_ack[0] && cack_cyc == 0) cack_cyc = k;
            if (latch_set[0] && latch_reset[0]) overlap++;
            #1;
            if (set_ack[0]) set_req[0] = 1'b0;
            if (clr_ack[0]) clr_req[0] = 1'b0;
        end
        checkInt("both_set_ack_cycle", sack_cyc, 3);
        checkInt("both_clr_ack_cycle", cack_cyc, 7);
        checkInt("both_overlap", overlap, 0);
        checkLit("both_q_shadow_end", q_shadow[0], 1'b0);

        // Feedback fault: err sets and survives later good pulses.
        stuck_low[0] = 1'b1;
        runReq(0, 1'b1, "fault_set_acked");
        checkLit("fault_err_set", err[0], 1'b1);
        stuck_low[0] = 1'b0;
        runReq(0, 1'b0, "good_clr_acked");
        checkLit("fault_err_sticky1", err[0], 1'b1);
        runReq(0, 1'b1, "good_set_acked");
        checkLit("fault_err_sticky2", err[0], 1'b1);
        checkLit("fault_q_shadow", q_shadow[0], 1'b1);

        // Asynchronous reset in the second cycle of a clear pulse.
        clr_req[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = latch_reset[0];
        end
        checkLit("abort_pulse_started", seen, 1'b1);
        @(posedge clk);
        #1 checkLit("abort_pulse_second_cycle", latch_reset[0], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        checkLit("abort_latch_reset", latch_reset[0], 1'b0);
        checkLit("abort_q_valid", q_valid[0], 1'b0);
        checkLit("abort_busy", busy[0], 1'b0);
        checkLit("abort_err_cleared", err[0], 1'b0);
        clr_req[0] = 1'b0;
        @(negedge clk);
        checkLit("abort_no_clr_ack", clr_ack[0], 1'b0);
        #1 rst_n = 1'b1;

        // Back-to-back clear then set on the 5/3 instance.
        clr_req[1] = 1'b1;
        rs_w = 0;
        ls_w = 0;
        last_rs = 0;
        first_ls = 0;
        first_rs = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (latch_reset[1]) begin
                rs_w++;
                last_rs = k;
                if (first_rs == 0) first_rs = k;
            end
            if (latch_set[1]) begin
                ls_w++;
                if (first_ls == 0) first_ls = k;
            end
            #1;
            if (k == 1) set_req[1] = 1'b1;
            if (clr_ack[1]) clr_req[1] = 1'b0;
            if (set_ack[1]) set_req[1] = 1'b0;
        end
        checkInt("p5_reset_width", rs_w, 5);
        checkInt("p5_set_width", ls_w, 5);
        checkInt("p5_reset_start", first_rs, 1);
        checkInt("p5_gap_cycles", first_ls - last_rs - 1, 4);
        checkLit("p5_q_shadow_end", q_shadow[1], 1'b1);

        // Randomized traffic, feedback faults and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1 applyStimulus();
        end
        set_req = '0;
        clr_req = '0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
